// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module  : register_file_mp_if
// Brief   : Port bundle for register_file_mp (two read, two write, clear).
// Revision: 1.0 - initial release
// ============================================================================
interface register_file_mp_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              we3;
    logic [ADDR_W-1:0] a3;
    logic [XLEN-1:0]   wd3;
    logic              we4;
    logic [ADDR_W-1:0] a4;
    logic [XLEN-1:0]   wd4;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic              clr;
    logic              busy;

    modport master (
        output we3, a3, wd3, we4, a4, wd4, a1, a2, clr,
        input  rd1, rd2, busy
    );

    modport slave (
        input  we3, a3, wd3, we4, a4, wd4, a1, a2, clr,
        output rd1, rd2, busy
    );
endinterface
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module  : register_file_mp
// Brief   : 2R/2W register file with optional zero register, write bypass
//           and a sequential bulk-clear engine.
// Revision: 1.0 - initial release
// ============================================================================
module register_file_mp #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    register_file_mp_if.slave   bus
);

    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;
    logic [XLEN-1:0]   r_regs [DEPTH];

    logic              w_we3_ok;
    logic              w_we4_ok;
    logic              w_byp_en;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < c_depth);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Writes are only accepted while the clear engine is idle.
    assign w_we3_ok = bus.we3 && !r_busy && in_range(bus.a3) && !is_zero_reg(bus.a3);
    assign w_we4_ok = bus.we4 && !r_busy && in_range(bus.a4) && !is_zero_reg(bus.a4);

    // Forwarding is suppressed during reset so reads stay 0 while rst is high.
    assign w_byp_en = (BYPASS != 0) && !r_busy && !rst;

    function automatic logic [XLEN-1:0] read_mux(input logic [ADDR_W-1:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (!in_range(addr) || is_zero_reg(addr)) begin
            val = '0;
        end else if (w_byp_en && bus.we4 && (bus.a4 == addr)) begin
            val = bus.wd4;
        end else if (w_byp_en && bus.we3 && (bus.a3 == addr)) begin
            val = bus.wd3;
        end else begin
            val = r_regs[addr];
        end
        return val;
    endfunction

    assign bus.rd1  = read_mux(bus.a1);
    assign bus.rd2  = read_mux(bus.a2);
    assign bus.busy = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_busy) begin
                    if (r_ptr == ADDR_W'(i)) begin
                        r_regs[i] <= '0;
                    end
                end else if (w_we4_ok && (bus.a4 == ADDR_W'(i))) begin
                    // Port 4 wins an address collision.
                    r_regs[i] <= bus.wd4;
                end else if (w_we3_ok && (bus.a3 == ADDR_W'(i))) begin
                    r_regs[i] <= bus.wd3;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.clr) begin
                        r_state <= CLEARING;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEARING: begin
                    if (r_ptr == c_last) begin
                        r_state <= IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ptr   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_register_file_mp
// Brief   : Directed self-checking bench for register_file_mp.
// Revision: 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] exp_regs [32];

    register_file_mp_if #(.XLEN(32), .ADDR_W(5)) bus ();

    register_file_mp #(
        .XLEN(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.we3 = 1'b0; bus.a3 = '0; bus.wd3 = '0;
        bus.we4 = 1'b0; bus.a4 = '0; bus.wd4 = '0;
        bus.a1  = '0;   bus.a2 = '0; bus.clr = 1'b0;
    endtask

    task automatic write3(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we3 = 1'b1; bus.a3 = a; bus.wd3 = d;
        @(negedge clk);
        bus.we3 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        bus.a1 = 5'd3; bus.a2 = 5'd31; #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %0b want 0", bus.busy);
        end
        checks++;
        if (bus.rd1 !== 32'd0 || bus.rd2 !== 32'd0) begin
            errors++; $display("FAIL reset_read got %h/%h want 0/0", bus.rd1, bus.rd2);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.rd1 !== 32'd0) begin
            errors++; $display("FAIL reset_after got %h want 0", bus.rd1);
        end
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    endtask

    task automatic test_lcg_fill();
        int x;
        x = 44;
        for (int i = 0; i < 32; i++) begin
            write3(5'(i), 32'(x));
            exp_regs[i] = (i == 0) ? 32'd0 : 32'(x);
            x = (3 * x + 177) % 201;
        end
        for (int i = 0; i < 32; i++) begin
            bus.a1 = 5'(i); bus.a2 = 5'(31 - i); #1;
            checks++;
            if (bus.rd1 !== exp_regs[i] || bus.rd2 !== exp_regs[31 - i]) begin
                errors++;
                $display("FAIL lcg_read[%0d] got %h/%h want %h/%h", i,
                         bus.rd1, bus.rd2, exp_regs[i], exp_regs[31 - i]);
            end
        end
        bus.a1 = 5'd1; #1;
        checks++;
        if (bus.rd1 !== 32'd108) begin
            errors++; $display("FAIL lcg_reg1 got %0d want 108", bus.rd1);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        bus.we3 = 1'b1; bus.a3 = 5'd0; bus.wd3 = 32'hDEADBEEF; bus.a1 = 5'd0; #1;
        checks++;
        if (bus.rd1 !== 32'd0) begin
            errors++; $display("FAIL zero_same_cycle got %h want 0", bus.rd1);
        end
        @(negedge clk);
        bus.we3 = 1'b0; #1;
        checks++;
        if (bus.rd1 !== 32'd0) begin
            errors++; $display("FAIL zero_next_cycle got %h want 0", bus.rd1);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        bus.we3 = 1'b1; bus.a3 = 5'd5; bus.wd3 = 32'h11;
        bus.we4 = 1'b1; bus.a4 = 5'd5; bus.wd4 = 32'h22;
        bus.a2 = 5'd5; #1;
        checks++;
        if (bus.rd2 !== 32'h22) begin
            errors++; $display("FAIL collision_bypass got %h want 22", bus.rd2);
        end
        @(negedge clk);
        bus.we3 = 1'b0; bus.we4 = 1'b0; #1;
        exp_regs[5] = 32'h22;
        checks++;
        if (bus.rd2 !== 32'h22) begin
            errors++; $display("FAIL collision_stored got %h want 22", bus.rd2);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        bus.we3 = 1'b1; bus.a3 = 5'd7; bus.wd3 = 32'h1234;
        bus.a1 = 5'd7; bus.a2 = 5'd6; #1;
        checks++;
        if (bus.rd1 !== 32'h1234) begin
            errors++; $display("FAIL bypass_port3 got %h want 1234", bus.rd1);
        end
        checks++;
        if (bus.rd2 !== exp_regs[6]) begin
            errors++; $display("FAIL bypass_other got %h want %h", bus.rd2, exp_regs[6]);
        end
        bus.we4 = 1'b1; bus.a4 = 5'd7; bus.wd4 = 32'h5678; #1;
        checks++;
        if (bus.rd1 !== 32'h5678) begin
            errors++; $display("FAIL bypass_port4 got %h want 5678", bus.rd1);
        end
        @(negedge clk);
        bus.we3 = 1'b0; bus.we4 = 1'b0; #1;
        exp_regs[7] = 32'h5678;
        checks++;
        if (bus.rd1 !== 32'h5678) begin
            errors++; $display("FAIL bypass_stored got %h want 5678", bus.rd1);
        end
    endtask

    task automatic test_clear();
        int n;
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (n == 3) begin
                // regs 0 and 1 already cleared; reg 9 still holds its value
                bus.we3 = 1'b1; bus.a3 = 5'd1; bus.wd3 = 32'd1;
                bus.a1 = 5'd1; bus.a2 = 5'd9; #1;
                checks++;
                if (bus.rd1 !== 32'd0) begin
                    errors++; $display("FAIL clear_no_bypass got %h want 0", bus.rd1);
                end
                checks++;
                if (bus.rd2 !== exp_regs[9]) begin
                    errors++; $display("FAIL clear_midread got %h want %h", bus.rd2, exp_regs[9]);
                end
            end
            @(negedge clk);
            bus.we3 = 1'b0;
        end
        checks++;
        if (n != 32) begin
            errors++; $display("FAIL clear_busy_len got %0d want 32", n);
        end
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
        for (int i = 0; i < 32; i++) begin
            bus.a1 = 5'(i); #1;
            checks++;
            if (bus.rd1 !== 32'd0) begin
                errors++; $display("FAIL clear_all[%0d] got %h want 0", i, bus.rd1);
            end
        end
    endtask

    task automatic test_reset_during_clear();
        int n;
        write3(5'd3, 32'hAA);
        write3(5'd30, 32'hBB);
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        repeat (9) @(negedge clk);
        bus.a1 = 5'd30; bus.a2 = 5'd3;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL abort_busy got %0b want 0", bus.busy);
        end
        checks++;
        if (bus.rd1 !== 32'd0 || bus.rd2 !== 32'd0) begin
            errors++; $display("FAIL abort_regs got %h/%h want 0/0", bus.rd1, bus.rd2);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.a1 = 5'(i); #1;
            checks++;
            if (bus.rd1 !== 32'd0) begin
                errors++; $display("FAIL abort_all[%0d] got %h want 0", i, bus.rd1);
            end
        end
        // A write in the CLR cycle still commits before the sweep reaches it.
        @(negedge clk);
        bus.clr = 1'b1; bus.we3 = 1'b1; bus.a3 = 5'd12; bus.wd3 = 32'h77;
        @(negedge clk);
        bus.clr = 1'b0; bus.we3 = 1'b0; bus.a1 = 5'd12; #1;
        checks++;
        if (bus.rd1 !== 32'h77) begin
            errors++; $display("FAIL clr_cycle_write got %h want 77", bus.rd1);
        end
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 32) begin
            errors++; $display("FAIL restart_busy_len got %0d want 32", n);
        end
        #1;
        checks++;
        if (bus.rd1 !== 32'd0) begin
            errors++; $display("FAIL restart_cleared got %h want 0", bus.rd1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lcg_fill();
        test_zero_reg();
        test_collision();
        test_bypass();
        test_clear();
        test_reset_during_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
